// File: rtl/verify_seq_pkg.sv
// Shared types for the step-verification sequencer: vector slots, verify records and FSM states.
package verify_seq_pkg;

  localparam int WORD_W = 64;
  localparam int STEP_BITS = 8;
  localparam int BITS_W = 7;

  typedef enum logic [1:0] {
    HEX,
    BINARY,
    US_DEC,
    SIGNED_DEC
  } fmt_t;

  typedef struct packed {
    logic [WORD_W-1:0] stim;
    logic [WORD_W-1:0] er;
    logic [BITS_W-1:0] er_bits;
    fmt_t              fmt;
  } vec_t;

  typedef struct packed {
    logic [STEP_BITS-1:0] step;
    logic [WORD_W-1:0]    er;
    logic [WORD_W-1:0]    ar;
    logic [BITS_W-1:0]    er_bits;
    logic [BITS_W-1:0]    ar_bits;
    fmt_t                 fmt;
    logic                 timeout;
  } rec_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    EMIT,
    FIN
  } state_t;

endpackage

// File: rtl/verify_vec_mem.sv
// Stimulus vector store: one synchronous write port, one combinational read port, contents kept across reset.
module verify_vec_mem
  import verify_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  vec_t                     wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output vec_t                     rdata
);

  vec_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/verify_step_sequencer.sv
// Drives stored stimulus vectors into a DUT one step at a time and emits one verify record per step.
module verify_step_sequencer
  import verify_seq_pkg::*;
#(
  parameter int WORD    = WORD_W,
  parameter int DEPTH   = 16,
  parameter int STEP_W  = STEP_BITS,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  vec_t                     ld_vec,
  input  logic                     start,
  input  logic [STEP_W-1:0]        num_steps,
  output logic                     dut_req,
  output logic [WORD-1:0]          dut_stim,
  input  logic                     dut_ack,
  input  logic [WORD-1:0]          dut_result,
  input  logic [BITS_W-1:0]        dut_result_bits,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output rec_t                     rec,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [STEP_W-1:0]   num_q, num_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                req_q, req_d;
  logic [WORD-1:0]     stim_q, stim_d;
  logic                rec_valid_q, rec_valid_d;
  rec_t                rec_q, rec_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                mem_we;
  logic [AW-1:0]       rd_addr;
  logic [AW-1:0]       addr_inc;
  vec_t                rd_vec;
  vec_t                slot;
  logic                rec_hs;
  logic                last_step;
  logic                timed_out;
  logic                enter_req;
  logic [STEP_W-1:0]   new_step;
  logic [AW-1:0]       new_addr;

  assign mem_we    = ld_we && !busy_q;
  assign addr_inc  = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
  assign rd_addr   = (state_q == IDLE) ? '0 : addr_inc;
  assign rec_hs    = rec_valid_q && rec_ready;
  assign last_step = (step_q == num_q);
  assign timed_out = (wait_q == WAIT_MAX);

  verify_vec_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(ld_addr),
    .wdata(ld_vec),
    .raddr(rd_addr),
    .rdata(rd_vec)
  );

  // A write landing in the same cycle as the start must be seen by step 1.
  always_comb begin
    slot = rd_vec;
    if (mem_we && (ld_addr == rd_addr)) slot = ld_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      num_q       <= '0;
      addr_q      <= '0;
      wait_q      <= '0;
      req_q       <= 1'b0;
      stim_q      <= '0;
      rec_valid_q <= 1'b0;
      rec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      num_q       <= num_d;
      addr_q      <= addr_d;
      wait_q      <= wait_d;
      req_q       <= req_d;
      stim_q      <= stim_d;
      rec_valid_q <= rec_valid_d;
      rec_q       <= rec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (num_steps != '0) ? REQ : FIN;
      REQ:  if (dut_ack || timed_out) state_d = EMIT;
      EMIT: if (rec_hs) state_d = last_step ? FIN : REQ;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step_d      = step_q;
    num_d       = num_q;
    addr_d      = addr_q;
    wait_d      = wait_q;
    req_d       = req_q;
    stim_d      = stim_q;
    rec_valid_d = rec_valid_q;
    rec_d       = rec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    enter_req   = 1'b0;
    new_step    = step_q + 1'b1;
    new_addr    = addr_inc;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_d = num_steps;
          if (num_steps != '0) begin
            enter_req = 1'b1;
            new_step  = STEP_W'(1);
            new_addr  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      REQ: begin
        wait_d = wait_q + 1'b1;
        if (dut_ack) begin
          req_d         = 1'b0;
          rec_valid_d   = 1'b1;
          rec_d.ar      = dut_result;
          rec_d.ar_bits = dut_result_bits;
          rec_d.timeout = 1'b0;
        end else if (timed_out) begin
          req_d         = 1'b0;
          rec_valid_d   = 1'b1;
          rec_d.ar      = '0;
          rec_d.ar_bits = '0;
          rec_d.timeout = 1'b1;
        end
      end
      EMIT: begin
        if (rec_hs) begin
          rec_valid_d = 1'b0;
          if (last_step) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            enter_req = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Every step begins by latching the slot so stimulus and record stay stable for the whole step.
    if (enter_req) begin
      step_d        = new_step;
      addr_d        = new_addr;
      wait_d        = '0;
      req_d         = 1'b1;
      busy_d        = 1'b1;
      stim_d        = slot.stim;
      rec_d.step    = new_step;
      rec_d.er      = slot.er;
      rec_d.er_bits = slot.er_bits;
      rec_d.fmt     = slot.fmt;
      rec_d.ar      = '0;
      rec_d.ar_bits = '0;
      rec_d.timeout = 1'b0;
    end
  end

  assign dut_req   = req_q;
  assign dut_stim  = stim_q;
  assign rec_valid = rec_valid_q;
  assign rec       = rec_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_verify_step_sequencer.sv
// Scoreboard bench for verify_step_sequencer: a spec-level model predicts every record, a monitor checks what the DUT emits.
module tb_verify_step_sequencer;
  import verify_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int TIMEOUT = 255;
  localparam int NO_ACK = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_we = 1'b0;
  logic [3:0]  ld_addr = '0;
  vec_t        ld_vec = '0;
  logic        start = 1'b0;
  logic [7:0]  num_steps = '0;
  logic        dut_req;
  logic [63:0] dut_stim;
  logic        dut_ack = 1'b0;
  logic [63:0] dut_result = '0;
  logic [6:0]  dut_result_bits = '0;
  logic        rec_valid;
  logic        rec_ready = 1'b1;
  rec_t        rec;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  verify_step_sequencer #(
    .WORD(64), .DEPTH(DEPTH), .STEP_W(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_vec(ld_vec),
    .start(start), .num_steps(num_steps), .dut_req(dut_req), .dut_stim(dut_stim),
    .dut_ack(dut_ack), .dut_result(dut_result), .dut_result_bits(dut_result_bits),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec(rec), .busy(busy), .done(done)
  );

  typedef struct {
    rec_t r;
    int   lat;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   plan_q[$];
  vec_t mem_model [DEPTH];
  int   cyc = 0;
  int   req_rise_cyc = 0;
  int   req_rises = 0;
  int   done_cnt = 0;
  int   recs_seen = 0;
  bit   ready_rand = 1'b0;
  bit   hold_req = 1'b0;
  int   hold_cnt = 0;

  function automatic logic [63:0] respVal(input logic [63:0] s);
    return s << 1;
  endfunction

  function automatic logic [6:0] respBits(input logic [63:0] s);
    return (s < 64'd16) ? 7'd64 : s[6:0];
  endfunction

  function automatic vec_t mkVec(input logic [63:0] s, input logic [63:0] e, input logic [6:0] b, input fmt_t f);
    vec_t v;
    v.stim = s; v.er = e; v.er_bits = b; v.fmt = f;
    return v;
  endfunction

  function automatic vec_t randVec();
    return mkVec({$urandom, $urandom}, {$urandom, $urandom}, 7'($urandom_range(1, 127)), fmt_t'($urandom_range(0, 3)));
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Expected record for each step follows directly from the slot contents and the ack delay the responder will use.
  task automatic planRun(input int n, input int delays[$]);
    exp_t e;
    vec_t v;
    for (int s = 1; s <= n; s++) begin
      int d;
      d = delays[s-1];
      plan_q.push_back(d);
      v = mem_model[(s-1) % DEPTH];
      e.r = '0;
      e.r.step = 8'(s);
      e.r.er = v.er;
      e.r.er_bits = v.er_bits;
      e.r.fmt = v.fmt;
      if (d <= TIMEOUT) begin
        e.r.ar = respVal(v.stim);
        e.r.ar_bits = respBits(v.stim);
        e.r.timeout = 1'b0;
        e.lat = d + 1;
      end else begin
        e.r.timeout = 1'b1;
        e.lat = TIMEOUT + 1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic loadSlot(input int a, input vec_t v);
    @(posedge clk); #1;
    ld_we = 1'b1; ld_addr = 4'(a); ld_vec = v;
    @(posedge clk); #1;
    ld_we = 1'b0;
    mem_model[a] = v;
  endtask

  task automatic applyStimulus(input int n, input bit wr, input int a, input vec_t v);
    @(posedge clk); #1;
    start = 1'b1; num_steps = 8'(n);
    ld_we = wr; ld_addr = 4'(a); ld_vec = v;
    @(posedge clk); #1;
    start = 1'b0; ld_we = 1'b0;
  endtask

  task automatic waitDone(input string name, input int base, input int budget);
    int k;
    k = 0;
    while (done_cnt == base && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    checkOutput({name, "_done_count"}, 256'(done_cnt - base), 256'(1));
    checkOutput({name, "_records_left"}, 256'(exp_q.size()), 256'(0));
    plan_q.delete();
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_dut_req"}, 256'(dut_req), 256'(0));
    checkOutput({name, "_dut_stim"}, 256'(dut_stim), 256'(0));
    checkOutput({name, "_rec_valid"}, 256'(rec_valid), 256'(0));
    checkOutput({name, "_rec"}, 256'(rec), 256'(0));
    checkOutput({name, "_busy"}, 256'(busy), 256'(0));
    checkOutput({name, "_done"}, 256'(done), 256'(0));
  endtask

  // Responder: acks each request after the planned number of cycles, or never.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (dut_req) begin
        int d;
        int k;
        d = (plan_q.size() > 0) ? plan_q.pop_front() : NO_ACK;
        k = 0;
        if (d == NO_ACK) begin
          while (dut_req) begin @(posedge clk); #1; end
        end else begin
          while (k < d && dut_req) begin @(posedge clk); #1; k++; end
          if (dut_req) begin
            dut_ack = 1'b1;
            dut_result = respVal(dut_stim);
            dut_result_bits = respBits(dut_stim);
            @(posedge clk); #1;
            dut_ack = 1'b0;
            dut_result = {$urandom, $urandom};
            dut_result_bits = 7'($urandom);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (hold_req && rec_valid) begin
        hold_req = 1'b0;
        hold_cnt = 5;
      end
      if (hold_cnt > 0) begin
        rec_ready = 1'b0;
        hold_cnt--;
      end else begin
        rec_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard when a new record is presented and checks protocol rules every cycle.
  initial begin
    rec_t held;
    bit   presenting;
    bit   prev_req;
    exp_t e;
    presenting = 1'b0;
    prev_req = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        presenting = 1'b0;
        prev_req = 1'b0;
      end else begin
        if (dut_req && !prev_req) begin
          req_rise_cyc = cyc;
          req_rises++;
        end
        prev_req = dut_req;
        if (done) begin
          done_cnt++;
          checkOutput("busy_low_at_done", 256'(busy), 256'(0));
        end
        if (rec_valid) begin
          checkOutput("no_req_while_rec_valid", 256'(dut_req), 256'(0));
          if (!presenting) begin
            recs_seen++;
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL unexpected_record actual=%0h expected=none", rec);
            end else begin
              e = exp_q.pop_front();
              checkOutput("record", 256'(rec), 256'(e.r));
              checkOutput("record_latency", 256'(cyc - req_rise_cyc), 256'(e.lat));
            end
            held = rec;
          end else begin
            checkOutput("record_stable", 256'(rec), 256'(held));
          end
          presenting = !rec_ready;
        end else begin
          presenting = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int rises;
    int seen;
    int k;
    int dl[$];
    vec_t v0;

    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    // Two directed steps with a fixed 3-cycle ack.
    loadSlot(0, mkVec(64'd5, 64'd10, 7'd64, HEX));
    loadSlot(1, mkVec(64'd7, 64'd14, 7'd64, HEX));
    dl = '{3, 3};
    planRun(2, dl);
    base = done_cnt;
    applyStimulus(2, 1'b0, 0, '0);
    checkOutput("start_busy", 256'(busy), 256'(1));
    checkOutput("start_dut_req", 256'(dut_req), 256'(1));
    checkOutput("start_dut_stim", 256'(dut_stim), 256'(mem_model[0].stim));
    checkOutput("start_rec_step", 256'(rec.step), 256'(1));
    waitDone("basic", base, 200);

    // Checker stalls the first record for five cycles.
    hold_req = 1'b1;
    dl = '{2, 1};
    planRun(2, dl);
    base = done_cnt;
    applyStimulus(2, 1'b0, 0, '0);
    waitDone("backpressure", base, 200);

    // First step never acknowledged.
    dl = '{NO_ACK, 0};
    planRun(2, dl);
    base = done_cnt;
    applyStimulus(2, 1'b0, 0, '0);
    waitDone("timeout", base, 800);

    // Empty run.
    base = done_cnt;
    rises = req_rises;
    seen = recs_seen;
    applyStimulus(0, 1'b0, 0, '0);
    checkOutput("zero_done_next", 256'(done), 256'(1));
    checkOutput("zero_busy", 256'(busy), 256'(0));
    @(posedge clk); #1;
    checkOutput("zero_done_single", 256'(done), 256'(0));
    repeat (3) @(posedge clk);
    checkOutput("zero_done_count", 256'(done_cnt - base), 256'(1));
    checkOutput("zero_no_req", 256'(req_rises - rises), 256'(0));
    checkOutput("zero_no_rec", 256'(recs_seen - seen), 256'(0));

    // Random run longer than the memory, with a same-cycle write of slot 0 and an ignored write while busy.
    for (int i = 0; i < DEPTH; i++) loadSlot(i, randVec());
    ready_rand = 1'b1;
    v0 = randVec();
    mem_model[0] = v0;
    dl.delete();
    for (int i = 0; i < 18; i++) dl.push_back(int'($urandom_range(0, 4)));
    planRun(18, dl);
    base = done_cnt;
    applyStimulus(18, 1'b1, 0, v0);
    repeat (2) @(posedge clk);
    #1;
    ld_we = 1'b1; ld_addr = 4'd15; ld_vec = randVec();
    @(posedge clk); #1;
    ld_we = 1'b0;
    waitDone("wrap18", base, 1000);
    ready_rand = 1'b0;

    // Reset while step 3 is waiting for its ack; the run is abandoned silently.
    dl = '{1, 1, 20, 1, 1};
    planRun(5, dl);
    base = done_cnt;
    rises = req_rises;
    applyStimulus(5, 1'b0, 0, '0);
    k = 0;
    while (req_rises < rises + 3 && k < 200) begin
      @(posedge clk);
      k++;
    end
    checkOutput("reached_step3", 256'(req_rises - rises), 256'(3));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkAllZero("midrun_reset");
    rst = 1'b0;
    exp_q.delete();
    plan_q.delete();
    repeat (5) @(posedge clk);
    checkOutput("midrun_no_done", 256'(done_cnt - base), 256'(0));

    // Vectors loaded before the reset are still there.
    dl = '{2, 2};
    planRun(2, dl);
    base = done_cnt;
    applyStimulus(2, 1'b0, 0, '0);
    checkOutput("restart_stim", 256'(dut_stim), 256'(mem_model[0].stim));
    waitDone("after_reset", base, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/verify_step_sequencer.md
Name: verify_step_sequencer

Overview:
- Synthesizable producer side of the step-verification interface: drives stimulus vectors into a DUT, captures each result, and emits one verify record per step (step number, expected/actual values and widths, display format) toward the checker.
- Replaces hand-written per-step bench code.
- Sits between a vector load port (bench or boot ROM loader), the DUT under test, and the pass/fail checker.

Parameters:
- WORD, `WORD, data width of stimulus, expected and actual values.
- DEPTH, 16, number of vector slots.
- STEP_W, 8, width of step number and of num_steps.
- TIMEOUT, 255, maximum cycles to wait for dut_ack before the step is declared timed out.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- ld_we  in  1  write one vector slot; ignored while busy.
- ld_addr  in  $clog2(DEPTH)  slot index.
- ld_vec  in  vec_t  {stim, er, er_bits, fmt}.
- start  in  1  begin run; ignored while busy.
- num_steps  in  STEP_W  steps to run; sampled on accepted start.
- dut_req  out  1  stimulus valid.
- dut_stim  out  WORD  stimulus value.
- dut_ack  in  1  result valid.
- dut_result  in  WORD  actual result.
- dut_result_bits  in  7  actual result width.
- rec_valid  out  1  record valid.
- rec_ready  in  1  checker accepts record.
- rec  out  rec_t  {step, er, ar, er_bits, ar_bits, fmt, timeout}.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- All outputs are registered. Reset value: every output 0, FSM in IDLE, step counter 0.
- Vector memory is not cleared by rst. Its contents survive reset.
- FSM states: IDLE, REQ, EMIT, FIN.
- IDLE:
  - start with num_steps>0 → REQ. busy=1 and dut_req=1 from the next cycle (latency 1). Slot 0 is on dut_stim; rec.step=1.
  - start with num_steps=0 → FIN.
- REQ:
  - dut_req is held high and dut_stim is held stable; the wait counter increments each cycle.
  - dut_ack is sampled every REQ cycle, including the first.
  - On ack, capture dut_result and dut_result_bits into ar and ar_bits, set timeout=0, drop dut_req, → EMIT. rec_valid is high the cycle after ack.
  - If the counter reaches TIMEOUT with no ack: ar=0, ar_bits=0, timeout=1, drop dut_req, → EMIT.
  - dut_ack outside REQ is ignored.
- EMIT:
  - rec_valid is held, and rec is stable, until rec_valid&&rec_ready.
  - On handshake, if the step equals num_steps → FIN. Otherwise increment the step and address, → REQ; the next dut_req rises the following cycle.
  - rec_ready asserted before rec_valid has no effect.
- FIN: done=1 for exactly one cycle, busy=0, → IDLE.
- Step numbers are 1-based. The memory address is step-1.
- num_steps > DEPTH: the address wraps modulo DEPTH and the step number keeps counting up to num_steps.
- er and er_bits are passed through from the slot unchanged. No comparison is done in this block.
- rst asserted in any state: next cycle IDLE, all outputs 0. A partial run is abandoned without a done pulse.
- ld_we and start in the same IDLE cycle: the write is performed and the run starts. Slot reads happen no earlier than the REQ entry, so the written value is used.

Decomposition:
- Package verify_seq_pkg holds:
  - fmt_t: HEX, BINARY, US_DEC, SIGNED_DEC.
  - vec_t and rec_t packed structs.
  - state_t enum.
  - localparam BITS_W=7.
- Sub-module verify_vec_mem: DEPTH×vec_t, one synchronous write port, one combinational read port, no reset.

Test Plan:
- Load slot0 {stim=5, er=10, er_bits=64, HEX}, slot1 {stim=7, er=14, er_bits=64, HEX}. start with num_steps=2. DUT acks 3 cycles after req with result=2*stim and result_bits=64. rec_ready=1 → records step1 ar=10, step2 ar=14, timeout=0; done pulses once; busy falls with done.
- Hold rec_ready=0 for 5 cycles in step 1 → rec stays stable and valid; no second dut_req until the handshake completes.
- DUT never acks, TIMEOUT=255 → record appears 256 cycles after req rose with ar=0, ar_bits=0, timeout=1; the run continues to the next step.
- num_steps=0 → no dut_req, no rec_valid, done pulses 1 cycle after start.
- DEPTH=16, num_steps=18 → steps 17 and 18 use slots 0 and 1; rec.step values are 17 and 18.
- rst in REQ of step 3 → next cycle all outputs 0, no done pulse. A new start runs from step 1 using the vectors loaded before reset.
